debounce_filter: RTL and testbench

Multi-channel switch debouncer that sits directly upstream of the LED toggle stage on the Go Board. It synchronises each raw push-button input to i_Clk and rejects bounce and glitches. Each debounced level is forwarded only after the raw input has held a new value for DEBOUNCE_LIMIT consecutive cycles. It also produces single-cycle press and release strobes, so downstream stages can act on clean edges without their own edge detector.

---
 rtl/debounce_filter.sv | 102 ++++++++++
 tb/tb_debounce_filter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Multi-channel push-button debouncer with press/release strobes.
// Raw inputs are synchronised, then filtered by a per-channel settle counter.
module debounce_filter #(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    logic [NUM_SWITCHES-1:0] sync1;
    logic [NUM_SWITCHES-1:0] sync2;

    // Two-flop synchroniser for the asynchronous switch levels
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
        end
    end

    for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_chan
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] count;
        logic [CW-1:0] count_nxt;
        logic          level;
        logic          level_nxt;
        logic          press;
        logic          press_nxt;
        logic          rel;
        logic          rel_nxt;

        // Channel state, counter and registered outputs
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                state <= STABLE;
                count <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_nxt;
                count <= count_nxt;
                level <= level_nxt;
                press <= press_nxt;
                rel   <= rel_nxt;
            end
        end

        // Next state: count mismatching cycles, accept at the limit
        always_comb begin
            state_nxt = state;
            count_nxt = count;
            level_nxt = level;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            unique case (state)
                STABLE: begin
                    if (sync2[n] != level) begin
                        state_nxt = SETTLING;
                        count_nxt = CW'(1);
                    end
                end
                SETTLING: begin
                    if (sync2[n] == level) begin
                        state_nxt = STABLE;
                        count_nxt = '0;
                    end else if (count == CNT_MAX) begin
                        state_nxt = STABLE;
                        count_nxt = '0;
                        level_nxt = sync2[n];
                        press_nxt = sync2[n];
                        rel_nxt   = ~sync2[n];
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            endcase
        end

        assign o_Switch[n]  = level;
        assign o_Press[n]   = press;
        assign o_Release[n] = rel;
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Randomised scoreboard bench for debounce_filter.
// Expected outputs come from a history-window model of the accept rule.
module tb_debounce_filter;

    localparam int NSW  = 4;
    localparam int LIM  = 4;
    localparam int NCYC = 3000;

    logic           clk;
    logic           rst;
    logic [NSW-1:0] sw_in;
    logic [NSW-1:0] sw_out;
    logic [NSW-1:0] press;
    logic [NSW-1:0] release_s;

    debounce_filter #(
        .NUM_SWITCHES  (NSW),
        .DEBOUNCE_LIMIT(LIM)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_Switch (sw_in),
        .o_Switch (sw_out),
        .o_Press  (press),
        .o_Release(release_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NSW-1:0] sw;
        logic [NSW-1:0] pr;
        logic [NSW-1:0] rl;
    } exp_t;

    exp_t           exp_q[$];
    logic [NSW-1:0] in_h [NCYC];
    bit             rst_h[NCYC];
    int             checks;
    int             errors;

    // Level the filter sees at edge k: raw input two edges earlier,
    // forced to 0 if either of those two edges was a reset edge.
    function automatic logic seen_at(int k, int ch);
        if (k < 2) return 1'b0;
        if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
        return in_h[k-2][ch];
    endfunction

    // Stimulus and reference model
    initial begin
        logic [NSW-1:0] mout;
        logic [NSW-1:0] lvl;
        int             hold[NSW];
        int             last_rst;
        int             rst_left;
        exp_t           e;
        mout     = '0;
        lvl      = '0;
        last_rst = -1;
        rst_left = 3;
        for (int c = 0; c < NSW; c++) hold[c] = $urandom_range(1, 8);
        for (int k = 0; k < NCYC; k++) begin
            if (rst_left == 0 && $urandom_range(0, 299) == 0)
                rst_left = $urandom_range(1, 3);
            for (int c = 0; c < NSW; c++) begin
                if (hold[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    if ($urandom_range(0, 2) == 0)
                        hold[c] = $urandom_range(8, 20);
                    else
                        hold[c] = $urandom_range(1, 7);
                end
                hold[c]--;
            end
            rst      = (rst_left > 0);
            sw_in    = lvl;
            rst_h[k] = rst;
            in_h[k]  = lvl;
            if (rst_left > 0) rst_left--;
            e.pr = '0;
            e.rl = '0;
            if (rst_h[k]) begin
                mout     = '0;
                last_rst = k;
            end else begin
                for (int c = 0; c < NSW; c++) begin
                    bit acc;
                    acc = (k - LIM + 1 > last_rst);
                    for (int j = 0; j < LIM; j++)
                        if (seen_at(k - j, c) == mout[c]) acc = 0;
                    if (acc) begin
                        mout[c] = ~mout[c];
                        e.pr[c] = mout[c];
                        e.rl[c] = ~mout[c];
                    end
                end
            end
            e.sw = mout;
            exp_q.push_back(e);
            @(negedge clk);
        end
    end

    // Monitor: pop one expectation per edge and compare
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty edge %0d", k);
            end else begin
                e = exp_q.pop_front();
                if (sw_out !== e.sw) begin
                    errors++;
                    $display("FAIL o_Switch edge %0d: got %b expected %b",
                             k, sw_out, e.sw);
                end
                checks++;
                if (press !== e.pr) begin
                    errors++;
                    $display("FAIL o_Press edge %0d: got %b expected %b",
                             k, press, e.pr);
                end
                checks++;
                if (release_s !== e.rl) begin
                    errors++;
                    $display("FAIL o_Release edge %0d: got %b expected %b",
                             k, release_s, e.rl);
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
